data_memory_be: RTL
===================

// Module: data_memory_be
// PURPOSE
// Parametrised byte-addressable data memory for the single-cycle RV32 core; successor to the word-only D-MEM.
// Adds RV32I sub-word access (LB/LH/LW/LBU/LHU, SB/SH/SW), an access-fault flag and a reset-clear engine.
// Sits between the ALU address output and the write-back mux; combinational read, synchronous write.
// PARAMETERS
// ADDR_WIDTH      8   byte-address width; word index = addr[ADDR_WIDTH-1:2]
// DEPTH           64  number of 32-bit words (>=2, <= 2**(ADDR_WIDTH-2))
// CLEAR_ON_RESET  1   1: reset walks and zeroes every word; 0: contents kept across reset
// PORTS
// clk          in   1           clock, all state changes on rising edge
// reset        in   1           synchronous, active-high
// addr         in   ADDR_WIDTH  byte address from ALU
// write_data   in   32          store data; byte/half taken from low bits
// mem_read     in   1           load enable
// mem_write    in   1           store enable
// funct3       in   3           000 B, 001 H, 010 W, 100 BU, 101 HU
// read_data    out  32          extended load result
// access_fault out  1           misaligned, illegal funct3 or out-of-range access
// busy         out  1           clear engine active; core must stall
// BEHAVIOUR
// - One clock; reset is synchronous and active-high; ports named clk and reset.
// - Reset values: busy=1 (CLEAR_ON_RESET=1) or 0 (CLEAR_ON_RESET=0); read_data=0; clear_idx=0.
// - FSM: CLEAR, READY. Posedge with reset=1 -> state=CLEAR (or READY if CLEAR_ON_RESET=0), clear_idx=0.
// - CLEAR: each posedge with reset=0 writes mem[clear_idx]=0 and increments clear_idx;
//   at clear_idx==DEPTH-1 go to READY. busy = (state==CLEAR), registered; high for exactly DEPTH cycles after reset drops.
// - Reset during CLEAR restarts at clear_idx=0. In CLEAR: stores ignored, read_data=0, access_fault=0.
// - Word index widx = addr[ADDR_WIDTH-1:2]; widx>=DEPTH is out-of-range (no wrap).
// - access_fault (combinational, only when mem_read|mem_write): funct3 in {011,110,111};
//   H/HU with addr[0]=1; W with addr[1:0]!=0; out-of-range.
// - Store (READY, mem_write, no fault), at posedge: B writes lane addr[1:0] with write_data[7:0];
//   H writes lanes {addr[1],0}..+1 with write_data[15:0]; W writes all 4 lanes. Other lanes unchanged.
// - Faulting store: memory unchanged. funct3 100/101 on store = fault.
// - Load (combinational, zero latency): select byte/half by addr[1:0]; B/H sign-extend, BU/HU zero-extend.
// - read_data=0 when mem_read=0, on fault, or busy (never X).
// - mem_read and mem_write same cycle, same word: read_data shows pre-write contents; new value visible after the edge.
// - Little-endian: lane 0 = bits [7:0].
// TESTING
// 1. reset 1 cycle, DEPTH=64 -> busy high 64 cycles, then 0; LW every word -> 0x00000000.
// 2. SW 0x8000_80FF @0x10; LB @0x10 -> 0xFFFFFFFF; LBU @0x11 -> 0x00000080; LH @0x12 -> 0xFFFF8000; LHU @0x12 -> 0x00008000.
// 3. SW 0x11223344 @0x20, SB 0xAA @0x21, SH 0xBEEF @0x22 -> LW @0x20 = 0xBEEFAA44.
// 4. SW @0x06, LH @0x03, funct3=011 @0x00 -> access_fault=1, read_data=0, memory unchanged.
// 5. ADDR_WIDTH=9, DEPTH=64: SW @0x100 -> access_fault=1; LW @0x000 unchanged (no alias).
// 6. reset pulsed at cycle 30 of clear, SW during busy -> busy lasts 64 cycles from second reset; SW dropped.

Source files
------------

// File: rtl/data_memory_be.sv
// Byte-addressable RV32 data memory: sub-word loads/stores, access-fault detection,
// and a post-reset clear engine that zeroes every word while asserting busy.
module data_memory_be #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DEPTH          = 64,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           write_data,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [2:0]            funct3,
    output logic [31:0]           read_data,
    output logic                  access_fault,
    output logic                  busy
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {S_CLEAR, S_READY} state_t;

    state_t          r_state;
    logic            r_busy;
    logic [IW-1:0]   r_clear_idx;
    logic [3:0][7:0] r_mem [DEPTH];

    logic [ADDR_WIDTH-3:0] w_widx;
    logic [IW-1:0]         w_idx;
    logic                  w_oor;
    logic                  w_fault;
    logic                  w_store;
    logic                  w_clr_we;
    logic [3:0][7:0]       w_word;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [31:0]           w_load;
    logic [3:0]            w_be;
    logic [3:0][7:0]       w_wlane;

    assign w_widx = addr[ADDR_WIDTH-1:2];
    assign w_idx  = w_widx[IW-1:0];
    // Out-of-range words fault instead of aliasing onto low memory.
    assign w_oor  = 32'(w_widx) >= 32'(DEPTH);

    always_comb begin
        w_fault = 1'b0;
        if (funct3 inside {3'b011, 3'b110, 3'b111})                  w_fault = 1'b1;
        if ((funct3 == 3'b001 || funct3 == 3'b101) && addr[0])        w_fault = 1'b1;
        if (funct3 == 3'b010 && addr[1:0] != 2'b00)                   w_fault = 1'b1;
        if (mem_write && (funct3 == 3'b100 || funct3 == 3'b101))      w_fault = 1'b1;
        if (w_oor)                                                    w_fault = 1'b1;
        w_fault = w_fault && (mem_read || mem_write) && !r_busy;
    end
    assign access_fault = w_fault;

    assign w_word = w_oor ? '0 : r_mem[w_idx];
    assign w_byte = w_word[addr[1:0]];
    assign w_half = addr[1] ? w_word[3:2] : w_word[1:0];

    always_comb begin
        w_load = '0;
        case (funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b010:  w_load = w_word;
            3'b100:  w_load = {24'h0, w_byte};
            3'b101:  w_load = {16'h0, w_half};
            default: w_load = '0;
        endcase
    end
    assign read_data = (mem_read && !w_fault && !r_busy) ? w_load : 32'h0;

    always_comb begin
        w_be    = 4'b0000;
        w_wlane = {4{write_data[7:0]}};
        case (funct3)
            3'b000: w_be[addr[1:0]] = 1'b1;
            3'b001: begin
                w_be    = addr[1] ? 4'b1100 : 4'b0011;
                w_wlane = {2{write_data[15:0]}};
            end
            3'b010: begin
                w_be    = 4'b1111;
                w_wlane = write_data;
            end
            default: w_be = 4'b0000;
        endcase
    end

    assign w_store  = mem_write && !w_fault && !r_busy && !reset;
    assign w_clr_we = r_busy && !reset;

    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[r_clear_idx] <= '0;
        end else if (w_store) begin
            for (int l = 0; l < 4; l++)
                if (w_be[l]) r_mem[w_idx][l] <= w_wlane[l];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
            r_busy      <= (CLEAR_ON_RESET != 0);
            r_clear_idx <= '0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_clear_idx <= r_clear_idx + 1'b1;
                    if (r_clear_idx == IW'(DEPTH - 1)) begin
                        r_state     <= S_READY;
                        r_busy      <= 1'b0;
                        r_clear_idx <= '0;
                    end
                end
                default: r_busy <= 1'b0;
            endcase
        end
    end

    assign busy = r_busy;
endmodule
